// File: rtl/au_scheduler_pkg.sv
// Opcode encodings and shared scheduler constants for the arithmetic unit path.
// The opcodes package is imported by both the scheduler and the arithmetic unit.
package opcodes;
    localparam int OPCODE_SIZE = 4;

    localparam logic [OPCODE_SIZE-1:0] OP_ADD = 4'd0;
    localparam logic [OPCODE_SIZE-1:0] OP_SUB = 4'd1;
    localparam logic [OPCODE_SIZE-1:0] OP_MUL = 4'd2;
    localparam logic [OPCODE_SIZE-1:0] OP_DIV = 4'd3;
    localparam logic [OPCODE_SIZE-1:0] OP_INC = 4'd4;
    localparam logic [OPCODE_SIZE-1:0] OP_DEC = 4'd5;
endpackage

package constants;
    localparam int WORD_SIZE = 19;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } au_sched_state_t;

    localparam int AU_MUL_LAT = 2;
    localparam int AU_DIV_LAT = 4;

    localparam logic [WORD_SIZE-1:0] AU_DIV0_RESULT = 19'h7FFFF;
endpackage

// File: rtl/au_scheduler_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last grant and wraps.
// Emits a one-hot grant and its encoded index; all zero when disabled.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    idx
);

    int              cand;
    logic [ID_W-1:0] sel;

    // Walk from lowest to highest priority so the nearest requester wins.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        cand = 0;
        sel  = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = (int'(last) + i) % NUM_REQ;
            sel  = ID_W'(cand);
            if (en && req[sel]) begin
                gnt      = '0;
                gnt[sel] = 1'b1;
                idx      = sel;
            end
        end
    end

endmodule

// File: rtl/au_scheduler.sv
// Shares one combinational arithmetic unit between requesters with per-opcode settle time.
// Optional AU_SCHED_DIV0_EN: divide-by-zero short-circuits with an error response.
module au_scheduler
    import opcodes::*;
    import constants::*;
#(
    parameter int NUM_REQ = 2,
    parameter int MUL_LAT = AU_MUL_LAT,
    parameter int DIV_LAT = AU_DIV_LAT,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_REQ-1:0]                    req_valid,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic [NUM_REQ-1:0][OPCODE_SIZE-1:0]   req_opcode,
    input  logic [NUM_REQ-1:0][WORD_SIZE-1:0]     req_operand_1,
    input  logic [NUM_REQ-1:0][WORD_SIZE-1:0]     req_operand_2,
    output logic [OPCODE_SIZE-1:0]                au_opcode,
    output logic [WORD_SIZE-1:0]                  au_operand_1,
    output logic [WORD_SIZE-1:0]                  au_operand_2,
    input  logic [WORD_SIZE-1:0]                  au_result,
    output logic                                  resp_valid,
    input  logic                                  resp_ready,
    output logic [ID_W-1:0]                       resp_id,
    output logic [WORD_SIZE-1:0]                  resp_result,
    output logic                                  resp_err,
    output logic                                  busy
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    au_sched_state_t        state;
    logic [ID_W-1:0]        last_grant;
    logic [ID_W-1:0]        win_idx;
    logic [NUM_REQ-1:0]     gnt;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       lat_m1;
    logic [OPCODE_SIZE-1:0] win_opcode;
    logic [WORD_SIZE-1:0]   win_op1;
    logic [WORD_SIZE-1:0]   win_op2;
    logic                   arb_en;
    logic                   div0_acc;
    logic                   div0_exec;

    assign arb_en = (state == IDLE) && rst_n;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req  (req_valid),
        .last (last_grant),
        .en   (arb_en),
        .gnt  (gnt),
        .idx  (win_idx)
    );

    assign req_ready  = gnt;
    assign win_opcode = req_opcode[win_idx];
    assign win_op1    = req_operand_1[win_idx];
    assign win_op2    = req_operand_2[win_idx];

`ifdef AU_SCHED_DIV0_EN
    assign div0_acc  = (win_opcode == OP_DIV) && (win_op2 == '0);
    assign div0_exec = (au_opcode == OP_DIV) && (au_operand_2 == '0);
`else
    assign div0_acc  = 1'b0;
    assign div0_exec = 1'b0;
`endif

    always_comb begin
        lat_m1 = '0;
        unique case (1'b1)
            (win_opcode == OP_MUL):
                lat_m1 = CNT_W'(MUL_LAT - 1);
            (win_opcode == OP_DIV) && !div0_acc:
                lat_m1 = CNT_W'(DIV_LAT - 1);
            default:
                lat_m1 = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_grant   <= ID_W'(NUM_REQ - 1);
            cnt          <= '0;
            au_opcode    <= '0;
            au_operand_1 <= '0;
            au_operand_2 <= '0;
            resp_valid   <= 1'b0;
            resp_id      <= '0;
            resp_result  <= '0;
            resp_err     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|gnt) begin
                        au_opcode    <= win_opcode;
                        au_operand_1 <= win_op1;
                        au_operand_2 <= win_op2;
                        last_grant   <= win_idx;
                        resp_id      <= win_idx;
                        cnt          <= lat_m1;
                        busy         <= 1'b1;
                        state        <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        resp_result <= div0_exec ? AU_DIV0_RESULT : au_result;
                        resp_err    <= div0_exec;
                        resp_valid  <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_au_scheduler.sv
// Directed bench for au_scheduler with a behavioural arithmetic unit model.
// Follows AU_SCHED_DIV0_EN to pick the divide-by-zero expectation.
module tb_au_scheduler;
    import opcodes::*;
    import constants::*;

    logic                                clk = 1'b0;
    logic                                rst_n = 1'b0;
    logic [1:0]                          req_valid = '0;
    logic [1:0]                          req_ready;
    logic [1:0][OPCODE_SIZE-1:0]         req_opcode = '0;
    logic [1:0][WORD_SIZE-1:0]           req_operand_1 = '0;
    logic [1:0][WORD_SIZE-1:0]           req_operand_2 = '0;
    logic [OPCODE_SIZE-1:0]              au_opcode;
    logic [WORD_SIZE-1:0]                au_operand_1;
    logic [WORD_SIZE-1:0]                au_operand_2;
    logic [WORD_SIZE-1:0]                au_result;
    logic                                resp_valid;
    logic                                resp_ready = 1'b1;
    logic [0:0]                          resp_id;
    logic [WORD_SIZE-1:0]                resp_result;
    logic                                resp_err;
    logic                                busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    au_scheduler u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_opcode    (req_opcode),
        .req_operand_1 (req_operand_1),
        .req_operand_2 (req_operand_2),
        .au_opcode     (au_opcode),
        .au_operand_1  (au_operand_1),
        .au_operand_2  (au_operand_2),
        .au_result     (au_result),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_id       (resp_id),
        .resp_result   (resp_result),
        .resp_err      (resp_err),
        .busy          (busy)
    );

    // Arithmetic unit model; divide by zero yields 0.
    always_comb begin
        au_result = '0;
        case (au_opcode)
            OP_ADD: au_result = au_operand_1 + au_operand_2;
            OP_SUB: au_result = au_operand_1 - au_operand_2;
            OP_MUL: au_result = au_operand_1 * au_operand_2;
            OP_DIV: au_result = (au_operand_2 == '0) ? '0 :
                                au_operand_1 / au_operand_2;
            OP_INC: au_result = au_operand_1 + 19'd1;
            OP_DEC: au_result = au_operand_1 - 19'd1;
            default: au_result = '0;
        endcase
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(int r, logic [OPCODE_SIZE-1:0] op,
                           logic [WORD_SIZE-1:0] a, logic [WORD_SIZE-1:0] b);
        req_opcode[r]    = op;
        req_operand_1[r] = a;
        req_operand_2[r] = b;
        req_valid[r]     = 1'b1;
    endtask

    // Returns the grant seen and how many negedges were waited; ends 1ns after the accept edge.
    task automatic accept(output logic [1:0] g, output int waited);
        g      = '0;
        waited = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req_ready != '0) begin
                g = req_ready;
                break;
            end
            @(negedge clk);
            waited++;
        end
        check("accept_seen", 32'(g != '0), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Counts edges from the accept edge until resp_valid is seen.
    task automatic wait_resp(output int lat);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            lat++;
            #1;
            if (resp_valid) break;
        end
    endtask

    logic [1:0] g;
    int         w;
    int         lat;

    initial begin
        // Reset state, with both requesters pushing during reset
        set_req(0, OP_ADD, 19'd1, 19'd1);
        set_req(1, OP_ADD, 19'd2, 19'd2);
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_au_op1", 32'(au_operand_1), 32'd0);
        check("rst_resp_result", 32'(resp_result), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        rst_n     = 1'b1;
        req_valid = '0;

        // Single ADD 10,5 from requester 0
        set_req(0, OP_ADD, 19'd10, 19'd5);
        accept(g, w);
        req_valid[0] = 1'b0;
        check("add_grant", 32'(g), 32'd1);
        check("add_busy", 32'(busy), 32'd1);
        check("add_au_op1", 32'(au_operand_1), 32'd10);
        check("add_valid_early", 32'(resp_valid), 32'd0);
        wait_resp(lat);
        check("add_lat", 32'(lat), 32'd1);
        check("add_result", 32'(resp_result), 32'd15);
        check("add_id", 32'(resp_id), 32'd0);
        check("add_err", 32'(resp_err), 32'd0);

        // Simultaneous MUL (req 0) and DIV (req 1) from reset
        rst_n     = 1'b0;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        set_req(0, OP_MUL, 19'd3, 19'd4);
        set_req(1, OP_DIV, 19'd20, 19'd4);
        accept(g, w);
        req_valid[0] = 1'b0;
        check("mul_grant", 32'(g), 32'd1);
        wait_resp(lat);
        check("mul_lat", 32'(lat), 32'd2);
        check("mul_result", 32'(resp_result), 32'd12);
        check("mul_id", 32'(resp_id), 32'd0);
        accept(g, w);
        req_valid[1] = 1'b0;
        check("div_grant", 32'(g), 32'd2);
        check("div_wait", 32'(w), 32'd2);
        wait_resp(lat);
        check("div_lat", 32'(lat), 32'd4);
        check("div_result", 32'(resp_result), 32'd5);
        check("div_id", 32'(resp_id), 32'd1);

        // Both requesters continuously valid with INC 10
        set_req(0, OP_INC, 19'd10, 19'd0);
        set_req(1, OP_INC, 19'd10, 19'd0);
        for (int k = 0; k < 4; k++) begin
            accept(g, w);
            check("inc_grant", 32'(g), (k % 2 == 0) ? 32'd1 : 32'd2);
            wait_resp(lat);
            check("inc_lat", 32'(lat), 32'd1);
            check("inc_result", 32'(resp_result), 32'd11);
            check("inc_id", 32'(resp_id), 32'(k % 2));
        end
        req_valid = '0;
        @(posedge clk);
        #1;

        // DEC 10 with response backpressure, requester 1 waiting
        resp_ready = 1'b0;
        set_req(0, OP_DEC, 19'd10, 19'd0);
        accept(g, w);
        req_valid[0] = 1'b0;
        check("dec_grant", 32'(g), 32'd1);
        wait_resp(lat);
        check("dec_lat", 32'(lat), 32'd1);
        set_req(1, OP_ADD, 19'd1, 19'd2);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_result", 32'(resp_result), 32'd9);
            check("hold_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hs_valid_drop", 32'(resp_valid), 32'd0);
        check("hs_next_ready", 32'(req_ready), 32'd2);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        check("post_hs_busy", 32'(busy), 32'd1);
        check("post_hs_id", 32'(resp_id), 32'd1);
        wait_resp(lat);
        check("post_hs_result", 32'(resp_result), 32'd3);
        @(posedge clk);
        #1;

        // DIV 7,0
        set_req(0, OP_DIV, 19'd7, 19'd0);
        accept(g, w);
        req_valid[0] = 1'b0;
        wait_resp(lat);
`ifdef AU_SCHED_DIV0_EN
        check("div0_lat", 32'(lat), 32'd1);
        check("div0_result", 32'(resp_result), 32'h7FFFF);
        check("div0_err", 32'(resp_err), 32'd1);
`else
        check("div0_lat", 32'(lat), 32'd4);
        check("div0_result", 32'(resp_result), 32'd0);
        check("div0_err", 32'(resp_err), 32'd0);
`endif
        @(posedge clk);
        #1;

        // Reset during EXEC of a DIV; last grant was requester 0
        set_req(0, OP_DIV, 19'd20, 19'd4);
        accept(g, w);
        check("rdiv_grant", 32'(g), 32'd1);
        req_valid = 2'b11;
        @(posedge clk);
        #1;
        check("rdiv_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rdiv_busy_rst", 32'(busy), 32'd0);
        check("rdiv_valid_rst", 32'(resp_valid), 32'd0);
        check("rdiv_au_op", 32'(au_opcode), 32'd0);
        check("rdiv_au_op1", 32'(au_operand_1), 32'd0);
        check("rdiv_au_op2", 32'(au_operand_2), 32'd0);
        check("rdiv_ready_rst", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rdiv_first_grant", 32'(req_ready), 32'd1);
        req_valid = '0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            check("rdiv_no_stale", 32'(resp_valid), 32'd0);
        end
        check("rdiv_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/au_scheduler.md
# au_scheduler

Sequencer and arbiter that shares the single combinational `arithmetic_unit` between `NUM_REQ` requesters. It grants requests round-robin and registers the selected opcode and operands onto the unit's inputs. It holds them for an opcode-dependent settle time, samples the result and returns it on a valid/ready response channel tagged with the requester ID. It sits between the issue logic and the arithmetic unit, so that MUL/DIV paths are given multicycle timing instead of closing in one cycle.

## Interface
- `NUM_REQ`, default 2: number of requesters (≥2).
- `MUL_LAT`, default 2: cycles from accept to `resp_valid` for MUL (≥1).
- `DIV_LAT`, default 4: cycles from accept to `resp_valid` for DIV (≥1).
- `ID_W`, default `$clog2(NUM_REQ)`: requester ID width.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  per-requester accept, one-hot or zero.
- `req_opcode`  in  NUM_REQ×OPCODE_SIZE  packed `[NUM_REQ-1:0][OPCODE_SIZE-1:0]`.
- `req_operand_1`, `req_operand_2`  in  NUM_REQ×WORD_SIZE  packed per requester.
- `au_opcode`  out  OPCODE_SIZE  to the arithmetic unit, registered.
- `au_operand_1`, `au_operand_2`  out  WORD_SIZE  to the arithmetic unit, registered.
- `au_result`  in  WORD_SIZE  arithmetic unit output.
- `resp_valid`  out  1  response valid.
- `resp_ready`  in  1  response accept.
- `resp_id`  out  ID_W  index of the requester served.
- `resp_result`  out  WORD_SIZE  registered result.
- `resp_err`  out  1  error flag (see Configuration).
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE → EXEC on request accept.
  - EXEC → RESP when the settle counter reaches 0.
  - RESP → IDLE on `resp_valid && resp_ready`.
- **IDLE arbitration:**
  - Round-robin over `req_valid`, starting at `last_grant+1` and wrapping at `NUM_REQ-1`→0.
  - The winner's `req_ready` is asserted combinationally. The accept edge registers its opcode and operands onto `au_*`, sets `last_grant`, and loads `resp_id`.
- **Settle latency:**
  - MUL uses `MUL_LAT`, DIV uses `DIV_LAT`, all other opcodes use 1.
  - The counter loads latency-1 on accept and decrements in EXEC.
  - On the edge where EXEC sees count 0, `au_result` is registered into `resp_result`.
- `req_ready` is 0 in EXEC and RESP. No accept is possible in the cycle the response handshakes; the next accept is at the earliest in the following cycle.
- **Requester obligations:**
  - Once a requester raises `req_valid`, it keeps it high with stable payload until `req_ready`.
  - A requester may drop an un-granted `req_valid`; the arbiter simply skips it.
- `au_*` hold their last values outside EXEC. The arithmetic unit is combinational, so this is harmless.
- Widths: all datapath values are `WORD_SIZE` (19) bits. No width conversion is done; the result is passed through as produced by the unit.

## Timing
- Reset values:
  - State IDLE, `last_grant`=NUM_REQ-1 (requester 0 has first priority).
  - `au_opcode`, `au_operand_*`, `resp_result`, `resp_id`, `resp_err` all 0.
  - `resp_valid`=0, `busy`=0, `req_ready`=0 while reset is asserted.
- Accept at edge N → `resp_valid` high after edge N+L, where L is the opcode latency. ADD therefore responds 1 cycle after accept.
- RESP holds `resp_valid`, `resp_id`, `resp_result` and `resp_err` stable until `resp_ready`. Backpressure is unbounded.
- Reset asserted mid-EXEC or mid-RESP: asynchronous return to the reset state; the in-flight operation is discarded with no response.

## Configuration
- `AU_SCHED_DIV0_EN`, when defined:
  - A DIV whose registered `operand_2`==0 does not wait `DIV_LAT`. It responds after 1 cycle with `resp_result`=19'h7FFFF and `resp_err`=1.
- When not defined:
  - DIV by 0 follows the normal path and returns whatever `au_result` is.
  - `resp_err` is tied to 0.

## Structure
- Shared `constants` package:
  - `au_sched_state_t` enum {IDLE, EXEC, RESP}.
  - Default latency constants `AU_MUL_LAT`=2 and `AU_DIV_LAT`=4.
  - Error result value `AU_DIV0_RESULT`=19'h7FFFF.
- Opcode values come from the `opcodes` package; no local literals.
- One sub-module, `rr_arbiter`:
  - Parameterised `NUM_REQ`.
  - Inputs: request vector, last-grant pointer, enable.
  - Output: one-hot grant plus encoded index.

## Test plan
- Single ADD 10,5 from requester 0, `resp_ready`=1 → `resp_valid` 1 cycle after accept with result 15, `resp_id`=0, `resp_err`=0.
- Simultaneous MUL 3,4 (req 0) and DIV 20,4 (req 1) from reset → req 0 served first with 12 after 2 cycles, then req 1 with 5 after 4 cycles.
- Both requesters continuously valid with INC 10 → grants alternate 0,1,0,1 and every result is 11.
- Hold `resp_ready`=0 for 3 cycles after a DEC 10 response → `resp_valid` and result 9 stay stable, `req_ready` stays 0, and the next accept comes 1 cycle after the handshake.
- DIV 7,0 with `AU_SCHED_DIV0_EN` → after 1 cycle, result 19'h7FFFF and `resp_err`=1. Without the macro → response after 4 cycles with `resp_err`=0.
- Assert `rst_n`=0 during EXEC of a DIV → `busy`, `resp_valid` and `au_*` go to 0 immediately. After release, the first request is granted to requester 0 and no stale response appears.
